// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity sense constants and the
// frame length helper used by both the transmitter and the future receiver.
package uart_pkg;

    // Transmitter/receiver frame states. Encodings not listed are unreachable.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Value XORed into the data reduction to form the parity bit.
    localparam logic UART_PARITY_EVEN = 1'b0;
    localparam logic UART_PARITY_ODD  = 1'b1;

    // Number of serial bit slots in one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(
        input int unsigned data_bits,
        input logic        parity_en,
        input int unsigned stop_bits
    );
        return 32'd1 + data_bits + (parity_en ? 32'd1 : 32'd0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLOCKS_PER_BIT cycles per serial bit and raises a
// registered one-cycle o_bit_end pulse in the last cycle of each bit period.
// Held at zero while i_clear is high so the first period starts cleanly.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 1302
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end_q, bit_end_d;

    // Next count: clear, wrap at the last cycle, otherwise increment; pulse is
    // precomputed so the registered flag lines up with the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        bit_end_d = (cnt_d == CNT_LAST);
    end

    // Counter and pulse registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign o_bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Valid/ready request handshake,
// one-cycle done pulse after the last stop bit. All outputs are registered.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit (sense set by
// PARITY_ODD); without it the frame is start + data + stop only.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 1302,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ODD     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_data_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_active,
    output logic                 o_tx_done,
    output logic                 o_tx_bit
);

    // Reject unsupported configurations at elaboration.
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLOCKS_PER_BIT < 2) begin : g_bad_clocks_per_bit
        $error("uart_tx_param: CLOCKS_PER_BIT must be at least 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end

    localparam int             IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_bit_q, tx_bit_d;
    logic                 active_q, active_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 timer_clear_s;
    logic                 bit_end_s;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_SENSE = (PARITY_ODD != 0) ? UART_PARITY_ODD : UART_PARITY_EVEN;
    logic parity_q, parity_d;
`endif

    // The timer free-runs only while a frame is on the line.
    assign timer_clear_s = (state_q == ST_IDLE);

    uart_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (timer_clear_s),
        .o_bit_end(bit_end_s)
    );

    // Frame sequencing: next state, shift register, indices and next output values.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_bit_d   = tx_bit_q;
        active_d   = active_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_bit_d   = 1'b1;
                active_d   = 1'b0;
                ready_d    = 1'b1;
                bit_idx_d  = {IDX_W{1'b0}};
                stop_idx_d = 1'b0;
                if (i_tx_data_valid && ready_q) begin
                    shift_d  = i_tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^i_tx_data) ^ PARITY_SENSE;
`endif
                    tx_bit_d = 1'b0;
                    active_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    tx_bit_d  = shift_q[0];
                    bit_idx_d = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        tx_bit_d = parity_q;
`else
                        state_d    = ST_STOP;
                        tx_bit_d   = 1'b1;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_bit_d  = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d    = ST_STOP;
                    tx_bit_d   = 1'b1;
                    stop_idx_d = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d  = ST_IDLE;
                        tx_bit_d = 1'b1;
                        active_d = 1'b0;
                        ready_d  = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a quiet idle line.
                state_d    = ST_IDLE;
                tx_bit_d   = 1'b1;
                active_d   = 1'b0;
                ready_d    = 1'b1;
                bit_idx_d  = {IDX_W{1'b0}};
                stop_idx_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= {DATA_BITS{1'b0}};
            bit_idx_q  <= {IDX_W{1'b0}};
            stop_idx_q <= 1'b0;
            tx_bit_q   <= 1'b1;
            active_q   <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_bit_q   <= tx_bit_d;
            active_q   <= active_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign o_tx_bit    = tx_bit_q;
    assign o_tx_active = active_q;
    assign o_tx_ready  = ready_q;
    assign o_tx_done   = done_q;

endmodule
